// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared pipeline definitions: the decoded control bundle carried from decode
// to execute, RV32I major opcodes, writeback-select and memory-access codes.
// No ports; imported with `import pipeline_pkg::*;`.
// -----------------------------------------------------------------------------
package pipeline_pkg;

   // RV32I major opcodes (instr[6:0])
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Writeback result select
   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   // Memory access size/sign (follows funct3 of loads/stores)
   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;

   // Decoded control bundle for one instruction slot
   typedef struct packed {
      logic       regwrite;
      logic       memwrite;
      logic       memread;
      logic       alusrc;
      logic       jump;
      logic       branch;
      logic       jalr;
      logic [1:0] resultsrc;
      logic [2:0] aluop;
      logic [2:0] immsrc;
      logic [2:0] memctrl;
      logic [2:0] funct3;
      logic       funct7b5;
   } ctrl_t;

endpackage

// File: rtl/decode_execute_reg_if.sv
// -----------------------------------------------------------------------------
// decode_execute_reg_if
// Bundle between decode stage / hazard unit (master) and the ID/EX register
// (slave). Master drives the D-side fields plus stallE/flushE and observes the
// registered E-side copies; slave is the opposite direction.
// -----------------------------------------------------------------------------
interface decode_execute_reg_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
);
   // hazard-unit controls
   logic              stallE, flushE;
   // decode side
   logic              validD;
   logic              regwriteD, memwriteD, memreadD, alusrcD, jumpD, branchD, jalrD;
   logic [1:0]        resultsrcD;
   logic [2:0]        aluopD, immsrcD, memctrlD, funct3D;
   logic              funct7b5D;
   logic [XLEN-1:0]   rd1D, rd2D, pcD, immextD, pcplus4D;
   logic [REG_AW-1:0] rs1D, rs2D, rdD;
   // execute side
   logic              validE;
   logic              regwriteE, memwriteE, memreadE, alusrcE, jumpE, branchE, jalrE;
   logic [1:0]        resultsrcE;
   logic [2:0]        aluopE, immsrcE, memctrlE, funct3E;
   logic              funct7b5E;
   logic [XLEN-1:0]   rd1E, rd2E, pcE, immextE, pcplus4E;
   logic [REG_AW-1:0] rs1E, rs2E, rdE;

   modport master (
      output stallE, flushE, validD,
             regwriteD, memwriteD, memreadD, alusrcD, jumpD, branchD, jalrD,
             resultsrcD, aluopD, immsrcD, memctrlD, funct3D, funct7b5D,
             rd1D, rd2D, pcD, immextD, pcplus4D, rs1D, rs2D, rdD,
      input  validE,
             regwriteE, memwriteE, memreadE, alusrcE, jumpE, branchE, jalrE,
             resultsrcE, aluopE, immsrcE, memctrlE, funct3E, funct7b5E,
             rd1E, rd2E, pcE, immextE, pcplus4E, rs1E, rs2E, rdE
   );

   modport slave (
      input  stallE, flushE, validD,
             regwriteD, memwriteD, memreadD, alusrcD, jumpD, branchD, jalrD,
             resultsrcD, aluopD, immsrcD, memctrlD, funct3D, funct7b5D,
             rd1D, rd2D, pcD, immextD, pcplus4D, rs1D, rs2D, rdD,
      output validE,
             regwriteE, memwriteE, memreadE, alusrcE, jumpE, branchE, jalrE,
             resultsrcE, aluopE, immsrcE, memctrlE, funct3E, funct7b5E,
             rd1E, rd2E, pcE, immextE, pcplus4E, rs1E, rs2E, rdE
   );
endinterface

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping. Only present when
// ID_EX_PERF_EN is defined.
// Ports: clk, rst_n (async active-low), en (count this edge), count (value).
// -----------------------------------------------------------------------------
`ifdef ID_EX_PERF_EN
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [WIDTH-1:0] count
);
   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_count <= '0;
      else if (en && (r_count != '1))
         r_count <= r_count + 1'b1;
   end

   assign count = r_count;
endmodule
`endif

// File: rtl/decode_execute_reg.sv
// -----------------------------------------------------------------------------
// decode_execute_reg
// ID/EX pipeline register. Captures decoded control and operands each edge,
// holds on stallE, inserts an all-zero bubble on flushE (flush wins).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bus (slave)    D-side inputs, stallE/flushE, registered E-side outputs
//   bubble_cntE    flush-edge count     (only with ID_EX_PERF_EN)
//   stall_cntE     stall-only edge count (only with ID_EX_PERF_EN)
// Optional feature macro: ID_EX_PERF_EN.
// -----------------------------------------------------------------------------
module decode_execute_reg
   import pipeline_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   decode_execute_reg_if.slave  bus
`ifdef ID_EX_PERF_EN
   ,
   output logic [31:0]          bubble_cntE,
   output logic [31:0]          stall_cntE
`endif
);

   typedef struct packed {
      logic [XLEN-1:0]   rd1;
      logic [XLEN-1:0]   rd2;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   immext;
      logic [XLEN-1:0]   pcplus4;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
   } data_t;

   ctrl_t w_ctrl_d, r_ctrl;
   data_t w_data_d, r_data;
   logic  r_valid;

   // NOTE: every field gets a value on every path, so no latch is inferred.
   always_comb begin
      w_ctrl_d           = '0;
      // Side-effecting bits die with an invalid slot; x0 writes never propagate.
      w_ctrl_d.regwrite  = bus.validD & bus.regwriteD & (bus.rdD != '0);
      w_ctrl_d.memwrite  = bus.validD & bus.memwriteD;
      w_ctrl_d.memread   = bus.validD & bus.memreadD;
      w_ctrl_d.jump      = bus.validD & bus.jumpD;
      w_ctrl_d.branch    = bus.validD & bus.branchD;
      w_ctrl_d.alusrc    = bus.alusrcD;
      w_ctrl_d.jalr      = bus.jalrD;
      w_ctrl_d.resultsrc = bus.resultsrcD;
      w_ctrl_d.aluop     = bus.aluopD;
      w_ctrl_d.immsrc    = bus.immsrcD;
      w_ctrl_d.memctrl   = bus.memctrlD;
      w_ctrl_d.funct3    = bus.funct3D;
      w_ctrl_d.funct7b5  = bus.funct7b5D;

      w_data_d         = '0;
      w_data_d.rd1     = bus.rd1D;
      w_data_d.rd2     = bus.rd2D;
      w_data_d.pc      = bus.pcD;
      w_data_d.immext  = bus.immextD;
      w_data_d.pcplus4 = bus.pcplus4D;
      w_data_d.rs1     = bus.rs1D;
      w_data_d.rs2     = bus.rs2D;
      w_data_d.rd      = bus.rdD;
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl  <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (bus.flushE) begin
         // Bubble: zeroed indices keep the forwarding unit from matching it.
         r_ctrl  <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (!bus.stallE) begin
         r_ctrl  <= w_ctrl_d;
         r_data  <= w_data_d;
         r_valid <= bus.validD;
      end
   end

   assign bus.validE     = r_valid;
   assign bus.regwriteE  = r_ctrl.regwrite;
   assign bus.memwriteE  = r_ctrl.memwrite;
   assign bus.memreadE   = r_ctrl.memread;
   assign bus.alusrcE    = r_ctrl.alusrc;
   assign bus.jumpE      = r_ctrl.jump;
   assign bus.branchE    = r_ctrl.branch;
   assign bus.jalrE      = r_ctrl.jalr;
   assign bus.resultsrcE = r_ctrl.resultsrc;
   assign bus.aluopE     = r_ctrl.aluop;
   assign bus.immsrcE    = r_ctrl.immsrc;
   assign bus.memctrlE   = r_ctrl.memctrl;
   assign bus.funct3E    = r_ctrl.funct3;
   assign bus.funct7b5E  = r_ctrl.funct7b5;
   assign bus.rd1E       = r_data.rd1;
   assign bus.rd2E       = r_data.rd2;
   assign bus.pcE        = r_data.pc;
   assign bus.immextE    = r_data.immext;
   assign bus.pcplus4E   = r_data.pcplus4;
   assign bus.rs1E       = r_data.rs1;
   assign bus.rs2E       = r_data.rs2;
   assign bus.rdE        = r_data.rd;

`ifdef ID_EX_PERF_EN
   logic w_stall_only;
   assign w_stall_only = bus.stallE & ~bus.flushE;

   sat_counter #(.WIDTH(32)) u_bubble_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bus.flushE),
      .count (bubble_cntE)
   );

   sat_counter #(.WIDTH(32)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_stall_only),
      .count (stall_cntE)
   );
`endif

endmodule

// File: tb/tb_decode_execute_reg.sv
// -----------------------------------------------------------------------------
// tb_decode_execute_reg
// Table-driven bench for the ID/EX register plus hand-written sequences for
// asynchronous reset and (with ID_EX_PERF_EN) the performance counters.
// -----------------------------------------------------------------------------
module tb_decode_execute_reg;
   import pipeline_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   decode_execute_reg_if #(.XLEN(32), .REG_AW(5)) bus ();

`ifdef ID_EX_PERF_EN
   logic [31:0] bubble_cntE, stall_cntE;
`endif

   decode_execute_reg #(.XLEN(32), .REG_AW(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef ID_EX_PERF_EN
      ,
      .bubble_cntE (bubble_cntE),
      .stall_cntE  (stall_cntE)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string       name;
      logic        stall, flush, valid, rw, mw, br;
      logic [2:0]  aluop;
      logic [4:0]  rd;
      logic [31:0] imm, rd1;
      logic        e_valid, e_rw, e_mw, e_br;
      logic [2:0]  e_aluop;
      logic [4:0]  e_rd;
      logic [31:0] e_imm, e_rd1;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(
      input string n, input logic st, fl, v, rw, mw, br, input logic [2:0] op,
      input logic [4:0] rd, input logic [31:0] imm, rd1,
      input logic ev, erw, emw, ebr, input logic [2:0] eop,
      input logic [4:0] erd, input logic [31:0] eimm, erd1);
      vec_t t;
      t.name = n; t.stall = st; t.flush = fl; t.valid = v; t.rw = rw; t.mw = mw;
      t.br = br; t.aluop = op; t.rd = rd; t.imm = imm; t.rd1 = rd1;
      t.e_valid = ev; t.e_rw = erw; t.e_mw = emw; t.e_br = ebr; t.e_aluop = eop;
      t.e_rd = erd; t.e_imm = eimm; t.e_rd1 = erd1;
      return t;
   endfunction

   // Remaining fields are driven from a per-vector pattern and tracked by a
   // small reference register that follows flush > stall > capture.
   logic [121:0] exp_misc;

   task automatic drive_misc(input int i);
      logic [3:0] b;
      b = i[3:0];
      bus.alusrcD    = b[0];
      bus.jalrD      = b[1];
      bus.jumpD      = b[2];
      bus.memreadD   = b[0] ^ b[1];
      bus.resultsrcD = b[1:0];
      bus.immsrcD    = b[2:0];
      bus.memctrlD   = b[2:0] + 3'd1;
      bus.funct3D    = ~b[2:0];
      bus.funct7b5D  = b[3];
      bus.rd2D       = 32'h1111_1111 * (i + 1);
      bus.pcD        = 32'h0000_1000 + 32'(4 * i);
      bus.pcplus4D   = 32'h0000_1004 + 32'(4 * i);
      bus.rs1D       = 5'(i + 1);
      bus.rs2D       = 5'(i + 2);
   endtask

   function automatic logic [121:0] misc_expect(input int i, input logic v);
      logic [3:0] b;
      b = i[3:0];
      return {b[0], b[1], b[2] & v, (b[0] ^ b[1]) & v, b[1:0], b[2:0],
              b[2:0] + 3'd1, ~b[2:0], b[3], 32'h1111_1111 * (i + 1),
              32'h0000_1000 + 32'(4 * i), 32'h0000_1004 + 32'(4 * i),
              5'(i + 1), 5'(i + 2)};
   endfunction

   function automatic logic [121:0] misc_actual();
      return {bus.alusrcE, bus.jalrE, bus.jumpE, bus.memreadE, bus.resultsrcE,
              bus.immsrcE, bus.memctrlE, bus.funct3E, bus.funct7b5E, bus.rd2E,
              bus.pcE, bus.pcplus4E, bus.rs1E, bus.rs2E};
   endfunction

   task automatic drive_lw();
      drive_misc(13);
      bus.stallE = 1'b0;   bus.flushE = 1'b0;   bus.validD = 1'b1;
      bus.regwriteD = 1'b1; bus.memwriteD = 1'b0; bus.branchD = 1'b0;
      bus.jumpD = 1'b0;    bus.memreadD = 1'b1; bus.alusrcD = 1'b1;
      bus.resultsrcD = RES_MEM; bus.memctrlD = MEM_W; bus.funct3D = MEM_W;
      bus.aluopD = 3'b000; bus.rdD = 5'd10;
      bus.immextD = 32'h0000_0008; bus.rd1D = 32'h0000_2000;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " validE"},    128'(bus.validE), 128'(0));
      check({tag, " regwriteE"}, 128'(bus.regwriteE), 128'(0));
      check({tag, " memreadE"},  128'(bus.memreadE), 128'(0));
      check({tag, " rdE"},       128'(bus.rdE), 128'(0));
      check({tag, " immextE"},   128'(bus.immextE), 128'(0));
      check({tag, " rd1E"},      128'(bus.rd1E), 128'(0));
      check({tag, " misc"},      128'(misc_actual()), 128'(0));
   endtask

   initial begin
      //            name          st fl v rw mw br op      rd  imm            rd1            ev erw emw ebr eop     erd  eimm           erd1
      vecs[0]  = mk("addi_x5",    0, 0, 1, 1, 0, 0, 3'b001, 5,  32'h0000_0010, 32'h0000_0100, 1, 1, 0, 0, 3'b001, 5,  32'h0000_0010, 32'h0000_0100);
      vecs[1]  = mk("write_x0",   0, 0, 1, 1, 0, 0, 3'b001, 0,  32'h0000_0020, 32'h0000_0200, 1, 0, 0, 0, 3'b001, 0,  32'h0000_0020, 32'h0000_0200);
      vecs[2]  = mk("invalid_d",  0, 0, 0, 1, 1, 1, 3'b010, 7,  32'h0000_0030, 32'h0000_0300, 0, 0, 0, 0, 3'b010, 7,  32'h0000_0030, 32'h0000_0300);
      vecs[3]  = mk("sw_capture", 0, 0, 1, 0, 1, 0, 3'b000, 0,  32'h0000_0004, 32'h0000_0400, 1, 0, 1, 0, 3'b000, 0,  32'h0000_0004, 32'h0000_0400);
      vecs[4]  = mk("stall_1",    1, 0, 1, 1, 0, 1, 3'b111, 12, 32'h0000_00FF, 32'hAAAA_0001, 1, 0, 1, 0, 3'b000, 0,  32'h0000_0004, 32'h0000_0400);
      vecs[5]  = mk("stall_2",    1, 0, 0, 0, 0, 0, 3'b110, 13, 32'h0000_01FF, 32'hAAAA_0002, 1, 0, 1, 0, 3'b000, 0,  32'h0000_0004, 32'h0000_0400);
      vecs[6]  = mk("stall_3",    1, 0, 1, 1, 1, 1, 3'b101, 14, 32'h0000_02FF, 32'hAAAA_0003, 1, 0, 1, 0, 3'b000, 0,  32'h0000_0004, 32'h0000_0400);
      vecs[7]  = mk("branch",     0, 0, 1, 0, 0, 1, 3'b011, 3,  32'h0000_0040, 32'h0000_0500, 1, 0, 0, 1, 3'b011, 3,  32'h0000_0040, 32'h0000_0500);
      vecs[8]  = mk("flush_stl",  1, 1, 1, 1, 0, 1, 3'b011, 8,  32'h0000_0050, 32'h0000_0600, 0, 0, 0, 0, 3'b000, 0,  32'h0000_0000, 32'h0000_0000);
      vecs[9]  = mk("hold_bub",   1, 0, 1, 1, 1, 0, 3'b001, 9,  32'h0000_0060, 32'h0000_0700, 0, 0, 0, 0, 3'b000, 0,  32'h0000_0000, 32'h0000_0000);
      vecs[10] = mk("x31_cap",    0, 0, 1, 1, 0, 0, 3'b100, 31, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 1, 1, 0, 0, 3'b100, 31, 32'hFFFF_FFFC, 32'hDEAD_BEEF);
      vecs[11] = mk("flush",      0, 1, 1, 1, 1, 1, 3'b111, 17, 32'h0000_0070, 32'h0000_0800, 0, 0, 0, 0, 3'b000, 0,  32'h0000_0000, 32'h0000_0000);

      // ---------------- reset state ----------------
      rst_n = 1'b0;
      drive_lw();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      exp_misc = '0;

      // ---------------- table ----------------
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive_misc(i);
         bus.stallE    = vecs[i].stall;
         bus.flushE    = vecs[i].flush;
         bus.validD    = vecs[i].valid;
         bus.regwriteD = vecs[i].rw;
         bus.memwriteD = vecs[i].mw;
         bus.branchD   = vecs[i].br;
         bus.aluopD    = vecs[i].aluop;
         bus.rdD       = vecs[i].rd;
         bus.immextD   = vecs[i].imm;
         bus.rd1D      = vecs[i].rd1;
         if (vecs[i].flush)       exp_misc = '0;
         else if (!vecs[i].stall) exp_misc = misc_expect(i, vecs[i].valid);
         @(posedge clk);
         #1;
         check({vecs[i].name, " validE"},    128'(bus.validE),    128'(vecs[i].e_valid));
         check({vecs[i].name, " regwriteE"}, 128'(bus.regwriteE), 128'(vecs[i].e_rw));
         check({vecs[i].name, " memwriteE"}, 128'(bus.memwriteE), 128'(vecs[i].e_mw));
         check({vecs[i].name, " branchE"},   128'(bus.branchE),   128'(vecs[i].e_br));
         check({vecs[i].name, " aluopE"},    128'(bus.aluopE),    128'(vecs[i].e_aluop));
         check({vecs[i].name, " rdE"},       128'(bus.rdE),       128'(vecs[i].e_rd));
         check({vecs[i].name, " immextE"},   128'(bus.immextE),   128'(vecs[i].e_imm));
         check({vecs[i].name, " rd1E"},      128'(bus.rd1E),      128'(vecs[i].e_rd1));
         check({vecs[i].name, " misc"},      128'(misc_actual()), 128'(exp_misc));
      end

      // ---------------- reset mid-run ----------------
      @(negedge clk);
      drive_lw();
      @(posedge clk);
      #1;
      check("lw validE",   128'(bus.validE), 128'(1));
      check("lw memreadE", 128'(bus.memreadE), 128'(1));
      check("lw rdE",      128'(bus.rdE), 128'(10));
      #2;
      rst_n = 1'b0;            // between edges: outputs must clear at once
      #1;
      check_all_zero("async_rst");
      @(posedge clk);
      #1;
      check_all_zero("rst_held");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst validE",    128'(bus.validE), 128'(1));
      check("post_rst regwriteE", 128'(bus.regwriteE), 128'(1));
      check("post_rst rdE",       128'(bus.rdE), 128'(10));
      check("post_rst immextE",   128'(bus.immextE), 128'(32'h0000_0008));

`ifdef ID_EX_PERF_EN
      // ---------------- performance counters ----------------
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("cnt_rst bubble", 128'(bubble_cntE), 128'(0));
      check("cnt_rst stall",  128'(stall_cntE), 128'(0));
      rst_n = 1'b1;
      bus.stallE = 1'b1; bus.flushE = 1'b1;     // flush with stall counts as bubble
      repeat (2) @(negedge clk);
      bus.stallE = 1'b0;                         // plain flushes
      repeat (2) @(negedge clk);
      bus.stallE = 1'b1; bus.flushE = 1'b0;     // stall-only
      repeat (2) @(negedge clk);
      bus.stallE = 1'b0;                         // idle capture
      @(negedge clk);
      check("perf bubble_cntE", 128'(bubble_cntE), 128'(4));
      check("perf stall_cntE",  128'(stall_cntE), 128'(2));
      dut.u_bubble_cnt.r_count = 32'hFFFF_FFFE;
      bus.flushE = 1'b1;
      repeat (3) @(negedge clk);
      bus.flushE = 1'b0;
      check("perf bubble_sat", 128'(bubble_cntE), 128'(32'hFFFF_FFFF));
      check("perf stall_keep", 128'(stall_cntE), 128'(2));
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Guard against a stalled simulation.
   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
